// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler
// Walks a small descriptor table (one config word and one base-address word
// per layer) on a single run command. For each layer it presents the config,
// lets it settle, pulses start and waits for the layer FSM's end-of-frame.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   i_desc_we/idx/cfg/base   descriptor table write port (dropped while busy)
//   i_num_layers             layer count, sampled when a run is accepted
//   i_run, i_abort           run / abort request pulses
//   i_end_frame              layer-done pulse from the layer FSM
//   o_layer_cfg, o_base_addr current layer descriptor (registered)
//   o_layer_idx              index of the current layer
//   o_start, o_done          one-cycle layer start / run done pulses
//   o_busy                   high from an accepted run until done or abort
//   o_err                    sticky flag for a run with an illegal count
module cnn_layer_scheduler #(
    parameter int N_LAYER    = 3,
    parameter int W_CFG      = 16,
    parameter int W_BASE     = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_desc_we,
    input  logic [3:0]        i_desc_idx,
    input  logic [W_CFG-1:0]  i_desc_cfg,
    input  logic [W_BASE-1:0] i_desc_base,
    input  logic [3:0]        i_num_layers,
    input  logic              i_run,
    input  logic              i_abort,
    input  logic              i_end_frame,
    output logic [W_CFG-1:0]  o_layer_cfg,
    output logic [W_BASE-1:0] o_base_addr,
    output logic [3:0]        o_layer_idx,
    output logic              o_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int IDX_W = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [3:0]       N_LAYER_4   = 4'(N_LAYER);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    state_e             state_q;
    logic [W_CFG-1:0]   cfg_tbl_q  [N_LAYER];
    logic [W_BASE-1:0]  base_tbl_q [N_LAYER];
    logic [3:0]         count_q;
    logic [3:0]         idx_q;
    logic [CNT_W-1:0]   settle_q;
    logic [W_CFG-1:0]   layer_cfg_q;
    logic [W_BASE-1:0]  base_addr_q;
    logic [3:0]         layer_idx_q;
    logic               start_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               desc_wr_en;
    logic               run_legal;
    logic [IDX_W-1:0]   wr_sel;
    logic [IDX_W-1:0]   rd_sel;

    // The table may only change while no run is reading it.
    assign desc_wr_en = i_desc_we && !busy_q && (i_desc_idx < N_LAYER_4);
    assign run_legal  = (i_num_layers != 4'd0) && (i_num_layers <= N_LAYER_4);
    // Both indices are range-limited to < N_LAYER, so the low bits suffice.
    assign wr_sel     = i_desc_idx[IDX_W-1:0];
    assign rd_sel     = idx_q[IDX_W-1:0];

    // Descriptor table storage, cleared by reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_LAYER; i++) begin
                cfg_tbl_q[i]  <= '0;
                base_tbl_q[i] <= '0;
            end
        end else if (desc_wr_en) begin
            cfg_tbl_q[wr_sel]  <= i_desc_cfg;
            base_tbl_q[wr_sel] <= i_desc_base;
        end else begin
            for (int i = 0; i < N_LAYER; i++) begin
                cfg_tbl_q[i]  <= cfg_tbl_q[i];
                base_tbl_q[i] <= base_tbl_q[i];
            end
        end
    end

    // Layer sequencing FSM with all outputs registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            count_q     <= 4'd0;
            idx_q       <= 4'd0;
            settle_q    <= '0;
            layer_cfg_q <= '0;
            base_addr_q <= '0;
            layer_idx_q <= 4'd0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Pulses default low; start/done are raised for one cycle only.
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_abort) begin
                // Descriptor outputs deliberately hold their last values.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_run) begin
                            if (run_legal) begin
                                count_q <= i_num_layers;
                                idx_q   <= 4'd0;
                                busy_q  <= 1'b1;
                                err_q   <= 1'b0;
                                state_q <= ST_LOAD;
                            end else begin
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        layer_cfg_q <= cfg_tbl_q[rd_sel];
                        base_addr_q <= base_tbl_q[rd_sel];
                        layer_idx_q <= idx_q;
                        settle_q    <= '0;
                        state_q     <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            start_q <= 1'b1;
                            state_q <= ST_WAIT;
                        end else begin
                            settle_q <= settle_q + CNT_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        // An end-of-frame coinciding with our own start pulse
                        // cannot belong to this layer, so it is ignored.
                        if (i_end_frame && !start_q) begin
                            if (idx_q == (count_q - 4'd1)) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                idx_q   <= idx_q + 4'd1;
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_layer_cfg = layer_cfg_q;
    assign o_base_addr = base_addr_q;
    assign o_layer_idx = layer_idx_q;
    assign o_start     = start_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Self-checking bench for cnn_layer_scheduler: directed plan steps plus
// randomized descriptor/run sequences checked against a table model and
// the cycle offsets of the sequencing rules.
module tb_cnn_layer_scheduler;

    localparam int N = 3;
    localparam int S = 2;

    logic        HCLK;
    logic        HRESETn;
    logic        i_desc_we;
    logic [3:0]  i_desc_idx;
    logic [15:0] i_desc_cfg;
    logic [31:0] i_desc_base;
    logic [3:0]  i_num_layers;
    logic        i_run;
    logic        i_abort;
    logic        i_end_frame;
    logic [15:0] o_layer_cfg;
    logic [31:0] o_base_addr;
    logic [3:0]  o_layer_idx;
    logic        o_start;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    // Reference table: what a run should read at each index.
    logic [15:0] mdl_cfg  [N];
    logic [31:0] mdl_base [N];

    cnn_layer_scheduler #(
        .N_LAYER(N), .W_CFG(16), .W_BASE(32), .SETTLE_CYC(S)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .i_desc_we(i_desc_we), .i_desc_idx(i_desc_idx),
        .i_desc_cfg(i_desc_cfg), .i_desc_base(i_desc_base),
        .i_num_layers(i_num_layers), .i_run(i_run), .i_abort(i_abort),
        .i_end_frame(i_end_frame),
        .o_layer_cfg(o_layer_cfg), .o_base_addr(o_base_addr),
        .o_layer_idx(o_layer_idx), .o_start(o_start), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  64'(o_busy),  64'd0);
        chk({tag, "_start"}, 64'(o_start), 64'd0);
        chk({tag, "_done"},  64'(o_done),  64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg"},  64'(o_layer_cfg), 64'd0);
        chk({tag, "_base"}, 64'(o_base_addr), 64'd0);
        chk({tag, "_idx"},  64'(o_layer_idx), 64'd0);
        chk({tag, "_err"},  64'(o_err),       64'd0);
        chk_idle(tag);
    endtask

    task automatic mdl_clear;
        for (int i = 0; i < N; i++) begin
            mdl_cfg[i]  = 16'd0;
            mdl_base[i] = 32'd0;
        end
    endtask

    // Idle-time descriptor write; the model keeps only in-range indices.
    task automatic write_desc(input int idx, input logic [15:0] c, input logic [31:0] b);
        i_desc_idx  = 4'(idx);
        i_desc_cfg  = c;
        i_desc_base = b;
        i_desc_we   = 1'b1;
        tick;
        i_desc_we   = 1'b0;
        if (idx < N) begin
            mdl_cfg[idx]  = c;
            mdl_base[idx] = b;
        end
    endtask

    // One run request with a given count. Each o_start is answered by an
    // end-of-frame 'gap' cycles later. 'spur' injects an end-of-frame in
    // SETTLE and in the start cycle plus a descriptor write while busy.
    // 'abort_layer' aborts in WAIT of that layer (-1: never).
    task automatic do_run(input int cnt, input int gap, input bit spur, input int abort_layer);
        int n;
        i_num_layers = 4'(cnt);
        i_run = 1'b1;
        tick;
        i_run = 1'b0;
        if (cnt < 1 || cnt > N) begin
            chk("illegal_err", 64'(o_err), 64'd1);
            for (int k = 0; k < 5; k++) begin
                chk_idle("illegal");
                tick;
            end
            return;
        end
        chk("run_busy", 64'(o_busy), 64'd1);
        chk("run_err_clr", 64'(o_err), 64'd0);
        for (int l = 0; l < cnt; l++) begin
            n = 0;
            tick;
            n++;
            chk("cfg_settle",  64'(o_layer_cfg), 64'(mdl_cfg[l]));
            chk("base_settle", 64'(o_base_addr), 64'(mdl_base[l]));
            chk("idx_settle",  64'(o_layer_idx), 64'(l));
            if (spur) begin
                // Busy write: must be dropped, so the model stays unchanged.
                i_end_frame = 1'b1;
                i_desc_we   = 1'b1;
                i_desc_idx  = 4'(l);
                i_desc_cfg  = 16'($urandom);
                i_desc_base = 32'($urandom);
            end
            tick;
            n++;
            i_end_frame = 1'b0;
            i_desc_we   = 1'b0;
            while (o_start !== 1'b1 && n < 40) begin
                tick;
                n++;
            end
            chk("start_lat",  64'(n), 64'(1 + S));
            chk("cfg_start",  64'(o_layer_cfg), 64'(mdl_cfg[l]));
            chk("base_start", 64'(o_base_addr), 64'(mdl_base[l]));
            chk("idx_start",  64'(o_layer_idx), 64'(l));
            chk("busy_start", 64'(o_busy), 64'd1);
            if (spur) i_end_frame = 1'b1;
            tick;
            i_end_frame = 1'b0;
            chk("start_width", 64'(o_start), 64'd0);
            if (l == abort_layer) begin
                i_abort = 1'b1;
                tick;
                i_abort = 1'b0;
                chk_idle("abort");
                chk("abort_idx", 64'(o_layer_idx), 64'(l));
                chk("abort_cfg", 64'(o_layer_cfg), 64'(mdl_cfg[l]));
                i_end_frame = 1'b1;
                tick;
                i_end_frame = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    chk_idle("post_abort");
                    tick;
                end
                return;
            end
            repeat (gap - 1) tick;
            i_end_frame = 1'b1;
            tick;
            i_end_frame = 1'b0;
            if (l == cnt - 1) begin
                chk("done_pulse", 64'(o_done), 64'd1);
                chk("done_busy",  64'(o_busy), 64'd0);
                tick;
                chk("done_width", 64'(o_done), 64'd0);
            end
        end
    endtask

    initial begin
        HRESETn      = 1'b1;
        i_desc_we    = 1'b0;
        i_desc_idx   = 4'd0;
        i_desc_cfg   = 16'd0;
        i_desc_base  = 32'd0;
        i_num_layers = 4'd0;
        i_run        = 1'b0;
        i_abort      = 1'b0;
        i_end_frame  = 1'b0;
        mdl_clear();
        #1 HRESETn = 1'b0;
        #1;
        chk_all_zero("reset");
        #20 HRESETn = 1'b1;
        tick;

        // Three-layer network from the plan, end-of-frame 10 cycles after start.
        write_desc(0, 16'h0005, 32'h0010_0000);
        write_desc(1, 16'h0104, 32'h0020_0400);
        write_desc(2, 16'h020E, 32'h0030_0800);
        do_run(3, 10, 1'b0, -1);

        // Single-layer latency.
        do_run(1, 3, 1'b0, -1);

        // Illegal counts set the sticky error; a legal run clears it.
        do_run(0, 1, 1'b0, -1);
        do_run(4, 1, 1'b0, -1);
        do_run(2, 4, 1'b0, -1);

        // Abort in WAIT of layer 1, then rerun from layer 0.
        do_run(3, 5, 1'b0, 1);
        do_run(3, 2, 1'b0, -1);

        // End-of-frame in IDLE is ignored.
        i_end_frame = 1'b1;
        tick;
        i_end_frame = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_idle("idle_eof");
            tick;
        end

        // Spurious end-of-frame and busy writes, then confirm the table.
        do_run(3, 3, 1'b1, -1);
        do_run(3, 2, 1'b0, -1);

        // Run and abort together in IDLE: stays idle.
        i_num_layers = 4'd2;
        i_run   = 1'b1;
        i_abort = 1'b1;
        tick;
        i_run   = 1'b0;
        i_abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_idle("run_abort");
            tick;
        end

        // Randomized descriptor writes and runs.
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++) begin
                write_desc(int'($urandom_range(0, 4)), 16'($urandom), 32'($urandom));
            end
            do_run(int'($urandom_range(0, 4)), int'($urandom_range(1, 6)),
                   1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of SETTLE clears outputs and table at once.
        i_num_layers = 4'd3;
        i_run = 1'b1;
        tick;
        i_run = 1'b0;
        tick;
        HRESETn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        mdl_clear();
        #4 HRESETn = 1'b1;
        tick;
        do_run(3, 2, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_scheduler.md
# cnn_layer_scheduler

Multi-layer sequencer for the CNN accelerator. It holds a small descriptor table with one layer-config word and one base-address word per layer. On a single run command it walks the table: it presents each layer's configuration to the layer datapath/FSM, pulses start, and waits for end-of-frame before moving on. Firmware therefore issues one command per network instead of one per layer, and the scheduler sits between the AHB register file and the layer FSM.

## Interface
Parameters:
- N_LAYER, 3: descriptor table depth (maximum layers per run), 1..15
- W_CFG, 16: layer-config word width (same bit layout as the LAYER_CONFIG register)
- W_BASE, 32: base-address word width (weight[19:0], param[31:20])
- SETTLE_CYC, 2: cycles the config is held stable before start, at least 1

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous, active-low
- i_desc_we  in  1  descriptor write strobe
- i_desc_idx  in  4  descriptor index written
- i_desc_cfg  in  W_CFG  config word written
- i_desc_base  in  W_BASE  base-address word written
- i_num_layers  in  4  number of layers to run; sampled on an accepted i_run
- i_run  in  1  run request, single-cycle pulse
- i_abort  in  1  abort request, single-cycle pulse
- i_end_frame  in  1  layer-done pulse from the layer FSM
- o_layer_cfg  out  W_CFG  current layer config, registered
- o_base_addr  out  W_BASE  current base addresses, registered
- o_layer_idx  out  4  index of the current layer
- o_start  out  1  layer start, one-cycle pulse
- o_busy  out  1  high from an accepted run until done or abort
- o_done  out  1  one-cycle pulse after the last layer ends
- o_err  out  1  sticky flag: illegal run request

## Operation
- Reset: every output is 0, the whole table is 0, and the state is IDLE.
- Descriptor write: when i_desc_we=1, o_busy=0 and i_desc_idx<N_LAYER, store cfg and base at that index on the clock edge. Any other write is dropped silently.
- States and transitions:
  - IDLE: on i_run with 1 ≤ i_num_layers ≤ N_LAYER, latch the count, set idx=0, set o_busy=1, clear o_err, go to LOAD. On i_run with an illegal count, set o_err=1 and stay in IDLE.
  - LOAD: register o_layer_cfg, o_base_addr and o_layer_idx from table[idx]; clear the settle counter; go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles. On the last one, register o_start=1 and go to WAIT.
  - WAIT: o_start falls after one cycle. On i_end_frame:
    - if idx == count−1: register o_done=1 and o_busy=0, go to IDLE.
    - otherwise: idx+1, go to LOAD.
- i_end_frame outside WAIT, or in the cycle o_start is high, is ignored.
- i_run while o_busy=1 is ignored; it sets no error.
- i_abort, in any state: next state IDLE, o_busy=0, o_start=0. o_done is not pulsed. o_layer_cfg, o_base_addr and o_layer_idx keep their values. i_abort takes priority over i_run and i_end_frame in the same cycle.
- Asynchronous reset mid-run returns to the reset state immediately; the table is cleared.
- Index arithmetic is 4-bit unsigned and cannot wrap, because the count is at most N_LAYER ≤ 15.

## Timing
- i_run accepted in cycle T: o_busy=1 at T+1. Config valid at T+2. o_start high exactly at T+2+SETTLE_CYC (T+4 at the default).
- i_end_frame in WAIT cycle E, not the last layer: new config at E+2, o_start at E+2+SETTLE_CYC.
- i_end_frame in WAIT cycle E, last layer: o_done=1 and o_busy=0 at E+1. A new i_run is accepted from E+1 onward.
- o_start and o_done are each exactly one cycle wide.
- Config outputs are stable from SETTLE entry until the next LOAD.
- Descriptor write: readable by a run accepted in the following cycle.

## Test plan
- Write 3 descriptors (cfg 0x0005/0x0104/0x020E, base 0x0010_0000/0x0020_0400/0x0030_0800). Run with count=3; answer each o_start with i_end_frame 10 cycles later. Expect:
  - 3 o_start pulses, idx 0,1,2, with matching cfg and base;
  - o_done one cycle after the 3rd end_frame; o_busy falls the same cycle.
- i_run at T with count=1: o_busy at T+1, o_start exactly at T+4, nothing at T+5.
- Run with count=0, then with count=4: o_err=1, o_busy stays 0, no o_start. A following legal run clears o_err.
- Abort in WAIT of layer 1: o_busy=0 next cycle, no o_done, and a later i_end_frame has no effect. A rerun restarts at idx 0.
- Spurious and colliding events:
  - i_end_frame pulsed in IDLE, in SETTLE, and in the o_start cycle: all ignored.
  - i_desc_we while busy: the table is unchanged, verified on the next run.
  - i_run and i_abort in the same IDLE cycle: stays IDLE.
- Assert HRESETn low in the middle of SETTLE: all outputs 0 at once, and the table reads back as 0 on a subsequent run (cfg=0).
